// File: rtl/adc_spi_emulator_mc.sv
// Multi-channel simultaneous-sampling serial ADC emulator.
// spi_clk/cs_n are oversampled on clk; {oe,dout} leave through a delay pipe.
`timescale 1ns/1ps
module adc_spi_emulator_mc #(
  parameter int DATA_W    = 10,
  parameter int NUM_CH    = 4,
  parameter int HIZ_BITS  = 2,
  parameter int NULL_BITS = 1,
  parameter int DOUT_DLY  = 7
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic                     spi_clk,
  input  logic                     cs_n,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  output logic [NUM_CH-1:0]        data_out,
  output logic [NUM_CH-1:0]        data_oe,
  output logic                     frame_done,
  output logic                     frame_err
);

  localparam int TOTAL = HIZ_BITS + NULL_BITS + DATA_W;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int PW    = 2 * NUM_CH;

  typedef enum logic [2:0] {
    IDLE, HIZ, NULL, DATA, DONE
  } state_t;

  state_t state, state_n;

  logic spi_s1, spi_s2, spi_d;
  logic cs_s1, cs_s2, cs_d;
  logic init_q, armed;
  logic spi_fall, cs_fall, cs_rise;

  logic [CW-1:0]            bit_cnt, cnt_n;
  logic [NUM_CH*DATA_W-1:0] sh;
  logic [NUM_CH-1:0]        oe_r, oe_n;
  logic [NUM_CH-1:0]        dout_r, dout_n;
  logic [NUM_CH-1:0]        in_msb, sh_msb, sh_nxt;
  logic                     load, shift, clr;
  logic                     done_p, err_p;
  logic [PW-1:0]            pipe [DOUT_DLY];

  // armed: a frame may start only after cs_n was really seen high
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      spi_s1 <= 1'b0;
      spi_s2 <= 1'b0;
      spi_d  <= 1'b0;
      cs_s1  <= 1'b1;
      cs_s2  <= 1'b1;
      cs_d   <= 1'b1;
      init_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      spi_s1 <= spi_clk;
      spi_s2 <= spi_s1;
      spi_d  <= spi_s2;
      cs_s1  <= cs_n;
      cs_s2  <= cs_s1;
      cs_d   <= cs_s2;
      init_q <= 1'b1;
      armed  <= armed | (init_q & cs_s1);
    end
  end

  assign spi_fall = spi_d & ~spi_s2;
  assign cs_fall  = cs_d & ~cs_s2 & armed;
  assign cs_rise  = ~cs_d & cs_s2;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      in_msb[k] = data_in[k*DATA_W + DATA_W - 1];
      sh_msb[k] = sh[k*DATA_W + DATA_W - 1];
      sh_nxt[k] = sh[k*DATA_W + DATA_W - 2];
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt;
    oe_n    = oe_r;
    dout_n  = dout_r;
    load    = 1'b0;
    shift   = 1'b0;
    clr     = 1'b0;
    done_p  = 1'b0;
    err_p   = 1'b0;
    if (state != IDLE && cs_rise) begin
      state_n = IDLE;
      oe_n    = '0;
      dout_n  = '0;
      clr     = 1'b1;
      err_p   = (state != DONE);
    end else begin
      unique case (state)
        IDLE: if (cs_fall) begin
          load  = 1'b1;
          cnt_n = '0;
          if (HIZ_BITS > 0) begin
            state_n = HIZ;
            oe_n    = '0;
            dout_n  = '0;
          end else if (NULL_BITS > 0) begin
            state_n = NULL;
            oe_n    = '1;
            dout_n  = '0;
          end else begin
            state_n = DATA;
            oe_n    = '1;
            dout_n  = in_msb;
          end
        end
        HIZ: if (spi_fall) begin
          cnt_n = bit_cnt + CW'(1);
          if (cnt_n == CW'(HIZ_BITS)) begin
            oe_n = '1;
            if (NULL_BITS > 0) begin
              state_n = NULL;
              dout_n  = '0;
            end else begin
              state_n = DATA;
              dout_n  = sh_msb;
            end
          end
        end
        NULL: if (spi_fall) begin
          cnt_n = bit_cnt + CW'(1);
          if (cnt_n == CW'(HIZ_BITS + NULL_BITS)) begin
            state_n = DATA;
            dout_n  = sh_msb;
          end
        end
        DATA: if (spi_fall) begin
          cnt_n = bit_cnt + CW'(1);
          if (cnt_n == CW'(TOTAL)) begin
            state_n = DONE;
            oe_n    = '0;
            dout_n  = '0;
            done_p  = 1'b1;
          end else begin
            shift  = 1'b1;
            dout_n = sh_nxt;
          end
        end
        DONE: ;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      oe_r       <= '0;
      dout_r     <= '0;
      sh         <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= cnt_n;
      oe_r       <= oe_n;
      dout_r     <= dout_n;
      frame_done <= done_p;
      frame_err  <= err_p;
      if (load) begin
        sh <= data_in;
      end else if (shift) begin
        for (int k = 0; k < NUM_CH; k++)
          sh[k*DATA_W +: DATA_W] <= sh[k*DATA_W +: DATA_W] << 1;
      end
    end
  end

  // an aborted frame also flushes bits still in flight
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < DOUT_DLY; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= clr ? '0 : {oe_r, dout_r};
      for (int i = 1; i < DOUT_DLY; i++)
        pipe[i] <= clr ? '0 : pipe[i-1];
    end
  end

  assign {data_oe, data_out} = pipe[DOUT_DLY-1];

endmodule

// File: tb/tb_adc_spi_emulator_mc.sv
// Scoreboard bench for adc_spi_emulator_mc: default build plus a
// 12-bit/2-channel build sharing the same cs_n/spi_clk.
`timescale 1ns/1ps
module tb_adc_spi_emulator_mc;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        spi_clk;
  logic        cs_n;
  logic [39:0] din1;
  logic [23:0] din2;
  logic [3:0]  dout1, oe1;
  logic [1:0]  dout2, oe2;
  logic        fd1, fe1, fd2, fe2;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int nd1 = 0, ne1 = 0, nd2 = 0, ne2 = 0;

  logic [7:0] q1 [$];
  logic [3:0] q2 [$];

  always #5 clk = ~clk;

  adc_spi_emulator_mc dut1 (
    .clk(clk), .reset_b(reset_b),
    .spi_clk(spi_clk), .cs_n(cs_n),
    .data_in(din1), .data_out(dout1),
    .data_oe(oe1), .frame_done(fd1),
    .frame_err(fe1)
  );

  adc_spi_emulator_mc #(
    .DATA_W(12), .NUM_CH(2), .HIZ_BITS(0),
    .NULL_BITS(2), .DOUT_DLY(1)
  ) dut2 (
    .clk(clk), .reset_b(reset_b),
    .spi_clk(spi_clk), .cs_n(cs_n),
    .data_in(din2), .data_out(dout2),
    .data_oe(oe2), .frame_done(fd2),
    .frame_err(fe2)
  );

  always @(negedge clk) begin
    nd1 <= nd1 + int'(fd1);
    ne1 <= ne1 + int'(fe1);
    nd2 <= nd2 + int'(fd2);
    ne2 <= ne2 + int'(fe2);
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // bit interval n follows the n-th spi_clk fall (n=0: after cs_n fall)
  function automatic logic [1:0] model(int n, int hiz, int nul,
                                       int dw, logic [31:0] w);
    if (n < hiz) return 2'b00;
    if (n < hiz + nul) return 2'b10;
    if (n < hiz + nul + dw) return {1'b1, w[dw-1-(n-hiz-nul)]};
    return 2'b00;
  endfunction

  function automatic logic [7:0] exp1(int n, logic [39:0] w);
    logic [3:0] oe, d;
    logic [1:0] r;
    for (int c = 0; c < 4; c++) begin
      r = model(n, 2, 1, 10, 32'(w[c*10 +: 10]));
      oe[c] = r[1];
      d[c]  = r[0];
    end
    return {oe, d};
  endfunction

  function automatic logic [3:0] exp2(int n, logic [23:0] w);
    logic [1:0] oe, d;
    logic [1:0] r;
    for (int c = 0; c < 2; c++) begin
      r = model(n, 0, 2, 12, 32'(w[c*12 +: 12]));
      oe[c] = r[1];
      d[c]  = r[0];
    end
    return {oe, d};
  endfunction

  // monitor 1: value before each fall, plus latency window checks
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge spi_clk or posedge cs_n);
      if (mon_en) begin
        #5;
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL underflow1 actual=empty expected=entry");
        end else begin
          e = q1.pop_front();
          if (cs_n) begin
            chk("last1", 32'({oe1, dout1}), 32'(e));
            #30;
            chk("oe_off1", 32'(oe1), 32'(0));
          end else begin
            chk("bit1", 32'({oe1, dout1}), 32'(e));
            #80;
            chk("early1", 32'({oe1, dout1}), 32'(e));
            #20;
            if (q1.size() > 0)
              chk("late1", 32'({oe1, dout1}), 32'(q1[0]));
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] e;
    forever begin
      @(negedge spi_clk or posedge cs_n);
      if (mon_en) begin
        #5;
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL underflow2 actual=empty expected=entry");
        end else begin
          e = q2.pop_front();
          chk("bit2", 32'({oe2, dout2}), 32'(e));
          if (cs_n) begin
            #30;
            chk("oe_off2", 32'(oe2), 32'(0));
          end
        end
      end
    end
  end

  task automatic run_frame(input int n,
                           input logic [39:0] w1,
                           input logic [23:0] w2);
    int d1, e1, d2, e2;
    d1 = nd1; e1 = ne1; d2 = nd2; e2 = ne2;
    din1 = w1;
    din2 = w2;
    @(posedge clk);
    #3;
    q1.push_back(exp1(0, w1));
    q2.push_back(exp2(0, w2));
    cs_n = 1'b0;
    #50;
    din1 = 40'({$urandom(), $urandom()});
    din2 = 24'($urandom());
    #100;
    for (int i = 1; i <= n; i++) begin
      q1.push_back(exp1(i, w1));
      q2.push_back(exp2(i, w2));
      spi_clk = 1'b0;
      #70;
      spi_clk = 1'b1;
      #70;
    end
    #130;
    cs_n = 1'b1;
    #300;
    chk("done1", 32'(nd1 - d1), 32'(n >= 13));
    chk("err1",  32'(ne1 - e1), 32'(n < 13));
    chk("done2", 32'(nd2 - d2), 32'(n >= 14));
    chk("err2",  32'(ne2 - e2), 32'(n < 14));
  endtask

  initial begin
    int d1, e1, d2, e2;
    reset_b = 1'b0;
    cs_n    = 1'b1;
    spi_clk = 1'b1;
    din1    = '0;
    din2    = '0;
    #23;
    chk("rst1", 32'({oe1, dout1, fd1, fe1}), 32'(0));
    chk("rst2", 32'({oe2, dout2, fd2, fe2}), 32'(0));
    reset_b = 1'b1;
    #100;
    mon_en = 1'b1;

    run_frame(13, {10'h000, 10'h3FF, 10'h155, 10'h2AB},
              {12'h35A, 12'hA5C});
    run_frame(6, 40'({$urandom(), $urandom()}), 24'($urandom()));
    run_frame(13, {4{10'h3C3}}, {2{12'hA5C}});

    // reset in the middle of the data phase, cs_n held low after it
    mon_en = 1'b0;
    din1 = 40'({$urandom(), $urandom()});
    @(posedge clk);
    #3;
    cs_n = 1'b0;
    #150;
    for (int i = 1; i <= 7; i++) begin
      spi_clk = 1'b0;
      #70;
      spi_clk = 1'b1;
      #70;
    end
    chk("pre_rst_oe1", 32'(oe1), 32'(4'hF));
    chk("pre_rst_oe2", 32'(oe2), 32'(2'h3));
    reset_b = 1'b0;
    #1;
    chk("mid_rst1", 32'({oe1, dout1, fd1, fe1}), 32'(0));
    chk("mid_rst2", 32'({oe2, dout2, fd2, fe2}), 32'(0));
    #20;
    reset_b = 1'b1;
    d1 = nd1; e1 = ne1; d2 = nd2; e2 = ne2;
    for (int i = 0; i < 15; i++) begin
      spi_clk = 1'b0;
      #105;
      chk("idle_oe1", 32'(oe1), 32'(0));
      chk("idle_oe2", 32'(oe2), 32'(0));
      #35;
      spi_clk = 1'b1;
      #70;
    end
    cs_n = 1'b1;
    #300;
    chk("idle_pulses", 32'((nd1 - d1) + (ne1 - e1) +
                           (nd2 - d2) + (ne2 - e2)), 32'(0));
    mon_en = 1'b1;

    run_frame(13, {4{10'h3C3}}, {12'h000, 12'hFFF});
    run_frame(20, 40'({$urandom(), $urandom()}), 24'($urandom()));
    run_frame(14, 40'({$urandom(), $urandom()}), 24'($urandom()));
    for (int k = 0; k < 6; k++)
      run_frame(int'($urandom_range(0, 22)),
                40'({$urandom(), $urandom()}), 24'($urandom()));

    #200;
    chk("q1_empty", 32'(q1.size()), 32'(0));
    chk("q2_empty", 32'(q2.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
